// File: rtl/led_sink_pkg.sv
// Shared types and sizes for the LED put-sink responder.
// Imported by the top level and its prescaler.
package led_sink_pkg;
   typedef enum logic {IDLE, SHOW} state_t;

   localparam int DEPTH = 2;
   localparam int OCC_W = $clog2(DEPTH + 1);

   function automatic int hold_w(input int ticks);
      return $clog2(ticks + 1);
   endfunction
endpackage

// File: rtl/tick_prescaler.sv
// Free-running prescaler; tick pulses one cycle when the count is all-ones.
// Reusable tick source for other board top levels.
module tick_prescaler
   import led_sink_pkg::*;
#(
   parameter int PRESCALE_BITS = 20
) (
   input  logic CLK,
   input  logic RST_N,
   output logic tick
);
   logic [PRESCALE_BITS-1:0] r_cnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_cnt <= '0;
      else        r_cnt <= r_cnt + 1'b1;
   end

   assign tick = &r_cnt;
endmodule

// File: rtl/led_put_sink.sv
// Action-method responder: accepts put(value), buffers two entries and
// shows each on the LEDs for HOLD_TICKS prescaler ticks.
module led_put_sink
   import led_sink_pkg::*;
#(
   parameter int WIDTH         = 4,
   parameter int PRESCALE_BITS = 20,
   parameter int HOLD_TICKS    = 2
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             put_EN,
   input  logic [WIDTH-1:0] put_ARG,
   output logic             put_RDY,
   output logic [WIDTH-1:0] led,
   output logic             busy,
   output logic             heartbeat
);
   localparam int HW = hold_w(HOLD_TICKS);
   localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_TICKS);

   logic             w_tick;
   state_t           r_state, w_state_n;
   logic [HW-1:0]    r_hold, w_hold_n;
   logic [WIDTH-1:0] r_led, w_led_n;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [OCC_W-1:0] r_occ;
   logic             r_head;
   logic             r_hb;
   logic             w_accept, w_push, w_pop, w_bypass, w_wr_idx;

   tick_prescaler #(.PRESCALE_BITS(PRESCALE_BITS)) u_tick (
      .CLK  (CLK),
      .RST_N(RST_N),
      .tick (w_tick)
   );

   assign put_RDY  = (r_occ != OCC_W'(DEPTH));
   assign w_accept = put_EN & put_RDY;
   assign w_push   = w_accept & ~w_bypass;
   assign w_wr_idx = r_head ^ r_occ[0];

   // Pop decisions only see entries stored before this edge.
   always_comb begin
      w_state_n = r_state;
      w_hold_n  = r_hold;
      w_led_n   = r_led;
      w_pop     = 1'b0;
      w_bypass  = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (r_occ != '0) begin
               w_pop     = 1'b1;
               w_led_n   = r_mem[r_head];
               w_hold_n  = HOLD_INIT;
               w_state_n = SHOW;
            end else if (w_accept) begin
               w_bypass  = 1'b1;
               w_led_n   = put_ARG;
               w_hold_n  = HOLD_INIT;
               w_state_n = SHOW;
            end
         end
         SHOW: begin
            if (w_tick) begin
               if (r_hold == HW'(1)) begin
                  if (r_occ != '0) begin
                     w_pop    = 1'b1;
                     w_led_n  = r_mem[r_head];
                     w_hold_n = HOLD_INIT;
                  end else begin
                     w_hold_n  = '0;
                     w_state_n = IDLE;
                  end
               end else begin
                  w_hold_n = r_hold - HW'(1);
               end
            end
         end
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state <= IDLE;
         r_hold  <= '0;
         r_led   <= '0;
         r_hb    <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_hold  <= w_hold_n;
         r_led   <= w_led_n;
         r_hb    <= r_hb ^ w_tick;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_occ  <= '0;
         r_head <= 1'b0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) r_mem[w_wr_idx] <= put_ARG;
         if (w_pop)  r_head <= ~r_head;
         if (w_push && !w_pop)      r_occ <= r_occ + OCC_W'(1);
         else if (w_pop && !w_push) r_occ <= r_occ - OCC_W'(1);
      end
   end

   assign led       = r_led;
   assign busy      = (r_state == SHOW);
   assign heartbeat = r_hb;
endmodule

// File: tb/tb_led_put_sink.sv
// Self-checking bench for led_put_sink with a queue-based reference model.
// Tick every 4 cycles, hold of 2 ticks, 4-bit values.
module tb_led_put_sink;
   localparam int W  = 4;
   localparam int PB = 2;
   localparam int HT = 2;

   logic         CLK = 1'b0;
   logic         RST_N;
   logic         put_EN;
   logic [W-1:0] put_ARG;
   logic         put_RDY;
   logic [W-1:0] led;
   logic         busy;
   logic         heartbeat;

   int n_cmp = 0;
   int n_bad = 0;

   led_put_sink #(.WIDTH(W), .PRESCALE_BITS(PB), .HOLD_TICKS(HT)) dut (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .put_EN   (put_EN),
      .put_ARG  (put_ARG),
      .put_RDY  (put_RDY),
      .led      (led),
      .busy     (busy),
      .heartbeat(heartbeat)
   );

   always #5 CLK = ~CLK;

   // Reference model: stored values, display window, tick phase.
   int m_q[$];
   bit m_show;
   int m_hold;
   int m_led;
   bit m_hb;
   int m_pcnt;
   bit m_loaded;
   int acc_log[$];
   int dut_log[$];
   int d_seen;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_show = 0; m_hold = 0; m_led = 0;
      m_hb = 0; m_pcnt = 0; m_loaded = 0;
      acc_log.delete();
      dut_log.delete();
   endtask

   task automatic model_edge(input bit en, input int arg);
      bit rdy, acc, tk;
      rdy = (m_q.size() != 2);
      acc = en && rdy;
      tk  = (m_pcnt == (1 << PB) - 1);
      m_loaded = 0;
      if (acc) acc_log.push_back(arg);
      if (!m_show) begin
         if (m_q.size() > 0) begin
            m_led = m_q.pop_front();
            m_hold = HT; m_show = 1; m_loaded = 1;
            if (acc) m_q.push_back(arg);
         end else if (acc) begin
            m_led = arg;
            m_hold = HT; m_show = 1; m_loaded = 1;
         end
      end else begin
         if (tk) begin
            if (m_hold == 1) begin
               if (m_q.size() > 0) begin
                  m_led = m_q.pop_front();
                  m_hold = HT; m_loaded = 1;
               end else begin
                  m_show = 0;
               end
            end else begin
               m_hold--;
            end
         end
         if (acc) m_q.push_back(arg);
      end
      if (tk) m_hb = !m_hb;
      m_pcnt = (m_pcnt + 1) % (1 << PB);
   endtask

   task automatic step(input bit en, input logic [W-1:0] arg);
      put_EN  = en;
      put_ARG = arg;
      @(posedge CLK);
      model_edge(en, int'(arg));
      #1;
      if (m_loaded) dut_log.push_back(int'(led));
      if (led === 4'hD) d_seen++;
      chk("led", led, m_led);
      chk("busy", busy, m_show);
      chk("heartbeat", heartbeat, m_hb);
      chk("put_RDY", put_RDY, m_q.size() != 2);
   endtask

   task automatic drain_and_score(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) step(0, '0);
      chk({tag, "_count"}, dut_log.size(), acc_log.size());
      for (int i = 0; i < acc_log.size() && i < dut_log.size(); i++)
         chk({tag, "_order"}, dut_log[i], acc_log[i]);
      acc_log.delete();
      dut_log.delete();
   endtask

   initial begin
      int waited, toggles;
      logic prev_hb;
      bit en;
      put_EN = 0; put_ARG = '0; d_seen = 0;
      model_reset();
      RST_N = 0;
      #12;
      chk("rst_led", led, 0);
      chk("rst_busy", busy, 0);
      chk("rst_hb", heartbeat, 0);
      chk("rst_rdy", put_RDY, 1);
      @(negedge CLK);
      RST_N = 1;

      // Single put from IDLE.
      step(1, 4'hA);
      chk("t2_led", led, 4'hA);
      chk("t2_busy", busy, 1);
      drain_and_score("t2", 16);
      chk("t2_led_kept", led, 4'hA);

      // Three back-to-back puts, a fourth while not ready.
      step(1, 4'hA);
      step(1, 4'hB);
      step(1, 4'hC);
      chk("t3_rdy_low", put_RDY, 0);
      d_seen = 0;
      step(1, 4'hD);
      drain_and_score("t3", 32);
      chk("t3_never_D", d_seen, 0);

      // Push coinciding with the popping tick edge.
      step(1, 4'h1);
      step(1, 4'h2);
      waited = 0;
      while (!(m_show && m_hold == 1 && m_q.size() == 1 &&
               m_pcnt == (1 << PB) - 1) && waited < 40) begin
         step(0, '0);
         waited++;
      end
      chk("t4_align_timeout", waited < 40, 1);
      step(1, 4'h7);
      chk("t4_led_older", led, 4'h2);
      chk("t4_rdy", put_RDY, 1);
      drain_and_score("t4", 32);

      // Idle liveness.
      toggles = 0;
      prev_hb = heartbeat;
      for (int i = 0; i < 64; i++) begin
         step(0, '0);
         if (heartbeat !== prev_hb) toggles++;
         prev_hb = heartbeat;
      end
      chk("t5_toggles", toggles, 16);
      chk("t5_busy", busy, 0);
      chk("t5_led", led, 4'h7);

      // Reset while showing with two entries buffered.
      step(1, 4'h3);
      step(1, 4'h4);
      step(1, 4'h6);
      #1;
      RST_N = 0;
      #1;
      chk("rst2_led", led, 0);
      chk("rst2_busy", busy, 0);
      chk("rst2_hb", heartbeat, 0);
      chk("rst2_rdy", put_RDY, 1);
      model_reset();
      @(negedge CLK);
      RST_N = 1;
      step(1, 4'h5);
      chk("rst2_after", led, 4'h5);
      drain_and_score("rst2", 16);

      // Random traffic, enable asserted regardless of ready.
      for (int i = 0; i < 200; i++) begin
         en = ($urandom_range(0, 3) == 0);
         step(en, W'($urandom));
      end
      drain_and_score("rand", 40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
